// File: rtl/mealy_stim_sequencer.sv
// Input conditioning and stimulus source for the Mealy sequence-detector FSM:
// synchronised/debounced buttons and switch, plus an LSB-first pattern shifter.
module mealy_stim_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PAT_W           = 8,
  localparam int IDX_W          = (PAT_W > 1) ? $clog2(PAT_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_step,
  input  logic             btn_load,
  input  logic             sw_x,
  input  logic             mode,
  input  logic [PAT_W-1:0] pat_in,
  output logic             x_out,
  output logic             step_pulse,
  output logic [IDX_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Channel order: 0 = step button, 1 = load button, 2 = manual x switch
  logic [2:0] w_raw;
  logic [2:0] w_deb;
  logic [2:0] r_deb_q;
  logic       r_step_req;
  logic       r_load_req;

  state_t           r_state;
  logic [PAT_W-1:0] r_shreg;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_step_pulse;
  logic             r_x_out;

  assign w_raw = {sw_x, btn_load, btn_step};

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_in
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_deb;

      // Synchronise the raw input, then accept a new level only after it has
      // differed from the debounced level for DEBOUNCE_CYCLES samples in a row.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_sync <= '0;
          r_cnt  <= '0;
          r_deb  <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
          if (r_sync[SYNC_STAGES-1] == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_deb <= ~r_deb;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_deb[g] = r_deb;
    end
  endgenerate

  // Rising-edge detect on the debounced buttons; each press yields one request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_deb_q    <= 3'b000;
      r_step_req <= 1'b0;
      r_load_req <= 1'b0;
    end else begin
      r_deb_q    <= w_deb;
      r_step_req <= w_deb[0] & ~r_deb_q[0];
      r_load_req <= w_deb[1] & ~r_deb_q[1];
    end
  end

  // Pattern control FSM; the shift happens on the edge that ends the pulse
  // cycle, so x_out holds the bit being consumed for the whole pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_step_pulse <= 1'b0;
      r_x_out      <= 1'b0;
    end else begin
      r_step_pulse <= r_step_req & ~r_load_req & (~mode | r_busy);
      r_x_out      <= mode ? r_shreg[0] : w_deb[2];
      if (r_load_req) begin
        r_state <= ST_SHIFT;
        r_shreg <= pat_in;
        r_idx   <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy <= 1'b0;
          end
          ST_SHIFT: begin
            if (r_step_pulse && mode) begin
              r_shreg <= r_shreg >> 1;
              if (r_idx == LAST_IDX) begin
                r_idx   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end else begin
              r_busy <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x_out      = r_x_out;
  assign step_pulse = r_step_pulse;
  assign bit_idx    = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_mealy_stim_sequencer.sv
// Scoreboard bench: a bit-indexed pattern model predicts every step_pulse and
// the end-of-press state; a separate monitor checks pulses as they appear.
module tb_mealy_stim_sequencer;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int PW   = 8;
  localparam int HOLD = 26;
  localparam int REL  = 26;

  typedef struct packed {
    logic       x;
    logic [2:0] idx;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_load = 1'b0;
  logic       sw_x = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] pat_in = 8'h00;
  logic       x_out, step_pulse, busy, done;
  logic [2:0] bit_idx;

  int n_vec = 0, n_err = 0, cyc = 0, n_pulse = 0, last_pulse_cyc = -1;
  logic prev_pulse = 1'b0;
  exp_t q[$];

  logic [7:0] m_pat = 8'h00;
  int         m_pos = 0;
  bit         m_busy = 1'b0, m_done = 1'b0, m_sw = 1'b0;

  mealy_stim_sequencer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .PAT_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_load(btn_load), .sw_x(sw_x),
    .mode(mode), .pat_in(pat_in), .x_out(x_out), .step_pulse(step_pulse),
    .bit_idx(bit_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must be one cycle wide and match the next expectation.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (step_pulse) begin
        exp_t e;
        n_pulse++;
        last_pulse_cyc = cyc;
        chk("pulse_width", int'(prev_pulse), 0);
        chk("pulse_expected", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("pulse_x", int'(x_out), int'(e.x));
          chk("pulse_idx", int'(bit_idx), int'(e.idx));
          chk("pulse_busy", int'(busy), int'(e.busy));
        end
      end
      prev_pulse = step_pulse;
    end
  end

  task automatic model_step();
    if (!mode) begin
      q.push_back(exp_t'{x: m_sw, idx: 3'(m_pos), busy: m_busy});
    end else if (m_busy) begin
      q.push_back(exp_t'{x: m_pat[m_pos], idx: 3'(m_pos), busy: 1'b1});
      m_pos++;
      if (m_pos == PW) begin
        m_pos  = 0;
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic model_load(input logic [7:0] p);
    m_pat  = p;
    m_pos  = 0;
    m_busy = 1'b1;
    m_done = 1'b0;
  endtask

  task automatic press(input logic s, input logic l);
    @(posedge clk); #1;
    btn_step = s;
    btn_load = l;
    repeat (HOLD) @(posedge clk);
    #1;
    btn_step = 1'b0;
    btn_load = 1'b0;
    repeat (REL) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string nm);
    logic ex;
    ex = mode ? (m_busy ? m_pat[m_pos] : 1'b0) : m_sw;
    chk({nm, "_idx"}, int'(bit_idx), m_pos);
    chk({nm, "_busy"}, int'(busy), int'(m_busy));
    chk({nm, "_done"}, int'(done), int'(m_done));
    chk({nm, "_x"}, int'(x_out), int'(ex));
  endtask

  task automatic do_step();
    model_step();
    press(1'b1, 1'b0);
    check_state("step");
  endtask

  task automatic do_load(input logic [7:0] p);
    pat_in = p;
    model_load(p);
    press(1'b0, 1'b1);
    check_state("load");
  endtask

  task automatic set_mode(input logic m);
    @(posedge clk); #1;
    mode = m;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic v);
    @(posedge clk); #1;
    sw_x = v;
    repeat (30) @(posedge clk);
    #1;
    m_sw = v;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      btn_step = ~btn_step;
      btn_load = ~btn_load;
      sw_x     = ~sw_x;
    end
    chk("rst_x", int'(x_out), 0);
    chk("rst_pulse", int'(step_pulse), 0);
    chk("rst_idx", int'(bit_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n  = 1'b1;
    m_pat  = 8'h00;
    m_pos  = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_sw   = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    m_sw = sw_x;
    check_state("post_rst");
  endtask

  initial begin
    int p0, hs, r;
    // Power-up reset with toggling inputs
    do_reset();

    // Bounced press then a clean hold: exactly one pulse at fixed latency
    set_mode(1'b0);
    p0 = n_pulse;
    repeat (4) begin
      btn_step = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      btn_step = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    model_step();
    btn_step = 1'b1;
    hs = cyc;
    repeat (40) @(posedge clk);
    #1;
    btn_step = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("deb_pulses", n_pulse - p0, 1);
    chk("deb_latency", last_pulse_cyc - hs, SYNC + DEB + 2);

    // Full pattern, then one extra step that must be dropped
    set_mode(1'b1);
    do_load(8'b1011_0010);
    for (int i = 0; i < 9; i++) do_step();
    chk("pat_done", int'(done), 1);

    // Manual steps leave pattern state alone
    set_mode(1'b0);
    set_sw(1'b1);
    for (int i = 0; i < 3; i++) do_step();

    // Simultaneous load and step: load wins, no pulse
    set_mode(1'b1);
    pat_in = 8'h3C;
    model_load(8'h3C);
    press(1'b1, 1'b1);
    check_state("collide");
    for (int i = 0; i < 5; i++) do_step();
    chk("pre_reload_idx", int'(bit_idx), 5);
    do_load(8'hFF);
    chk("reload_x", int'(x_out), 1);
    chk("reload_done", int'(done), 0);

    // Mode freeze mid-pattern
    do_load(8'h5A);
    for (int i = 0; i < 3; i++) do_step();
    set_mode(1'b0);
    do_step();
    do_step();
    set_mode(1'b1);
    chk("freeze_idx", int'(bit_idx), 3);
    check_state("freeze");

    // Reset mid-pattern abandons it
    do_step();
    do_reset();

    // Randomised operations
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        do_step();
      end else if (r <= 6) begin
        do_load(8'($urandom));
      end else if (r == 7) begin
        set_mode(~mode);
        check_state("mode");
      end else if (r == 8) begin
        set_sw(~sw_x);
        check_state("sw");
      end else begin
        pat_in = 8'($urandom);
        model_load(pat_in);
        press(1'b1, 1'b1);
        check_state("rnd_collide");
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
